// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory line responder: line geometry,
// request-counter width and the responder FSM state encoding.
package dmem_pkg;

   localparam int unsigned LINE_W   = 256;
   localparam int unsigned OFFSET_W = 5;
   localparam int unsigned CNT_W    = 8;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_e;

   // Counter preset loaded on the accept edge so ack rises LATENCY edges later.
   function automatic cnt_t latency_preset(input int unsigned latency);
      return cnt_t'(latency - 1);
   endfunction

endpackage

// File: rtl/dmem_line_array.sv
// Single-port synchronous line RAM, 2**ADDR_W x LINE_W, registered read data
// (read-before-write on the same address).
module dmem_line_array #(
   parameter int unsigned LINE_W = dmem_pkg::LINE_W,
   parameter int unsigned ADDR_W = 9
) (
   input  logic              clk_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              we_i,
   input  logic [LINE_W-1:0] data_i,
   output logic [LINE_W-1:0] data_o
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [LINE_W-1:0] mem_q [0:DEPTH-1];
   logic [LINE_W-1:0] rd_q;

   // Contents are deliberately never reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= data_i;
      end
      rd_q <= mem_q[addr_i];
   end

   assign data_o = rd_q;

endmodule

// File: rtl/dmem_line_responder.sv
// Data-memory responder for the 256-bit dcache line port: accepts one line
// read/write, waits a fixed LATENCY, then pulses ack_o for one cycle.
module dmem_line_responder #(
   parameter int unsigned LINE_W  = dmem_pkg::LINE_W,
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned LATENCY = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic              write_i,
   input  logic [31:0]       addr_i,
   input  logic [LINE_W-1:0] data_i,
   output logic              ack_o,
   output logic [LINE_W-1:0] data_o
);

   import dmem_pkg::*;

   localparam cnt_t LAT_PRESET = latency_preset(LATENCY);

   state_e              state_q, state_d;
   cnt_t                cnt_q, cnt_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [LINE_W-1:0]   wdata_q, wdata_d;
   logic                ack_q, ack_d;
   logic [LINE_W-1:0]   rdata_q, rdata_d;

   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_we;
   logic [LINE_W-1:0]   mem_rdata;
   logic                accept;
   logic                done;

   logic                unused_addr_bits;
   assign unused_addr_bits = ^{addr_i[31:OFFSET_W+ADDR_W], addr_i[OFFSET_W-1:0]};

   assign accept = (state_q == IDLE) && enable_i;
   assign done   = (state_q == WAIT) && (cnt_q == '0);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (enable_i) state_d = WAIT;
         WAIT:    if (cnt_q == '0) state_d = ACK;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      if (accept) begin
         wr_d    = write_i;
         idx_d   = addr_i[OFFSET_W +: ADDR_W];
         wdata_d = data_i;
         cnt_d   = LAT_PRESET;
      end else if ((state_q == WAIT) && (cnt_q != '0)) begin
         cnt_d = cnt_q - cnt_t'(1);
      end
   end

   // The RAM sees the incoming index while idle so its registered read is
   // already valid one edge after accept, which makes LATENCY=1 work.
   always_comb begin
      ack_d    = 1'b0;
      rdata_d  = rdata_q;
      mem_we   = 1'b0;
      mem_addr = (state_q == IDLE) ? addr_i[OFFSET_W +: ADDR_W] : idx_q;
      if (done) begin
         ack_d = 1'b1;
         if (wr_q) begin
            mem_we = 1'b1;
         end else begin
            rdata_d = mem_rdata;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
      end
   end

   dmem_line_array #(
      .LINE_W (LINE_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk_i  (clk_i),
      .addr_i (mem_addr),
      .we_i   (mem_we),
      .data_i (wdata_q),
      .data_o (mem_rdata)
   );

   assign ack_o  = ack_q;
   assign data_o = rdata_q;

endmodule
